adder64_operand_loader: RTL



---
 rtl/adder64_pkg.sv | 18 +
 rtl/adder64_operand_loader_if.sv | 38 +++
 rtl/adder64_operand_loader_fa.sv | 22 ++
 rtl/adder64_operand_loader.sv | 106 ++++++++++
 4 files changed

// File: rtl/adder64_pkg.sv
// Shared constants and types for the 64-bit adder operand loader.
// Optional overflow output is enabled with ADDER64_OVERFLOW_EN.
package adder64_pkg;

    localparam int BEAT_W       = 16;
    localparam int BEATS_PER_OP = 4;
    localparam int TOTAL_BEATS  = 8;
    localparam int OP_W         = BEAT_W * BEATS_PER_OP;

    typedef enum logic [1:0] {
        LOAD,
        CALC,
        DONE
    } state_t;

    typedef logic [2:0] cnt_t;

endpackage

// File: rtl/adder64_operand_loader_if.sv
// Beat input bus and result output bus of the operand loader.
// Ov is present only with ADDER64_OVERFLOW_EN.
interface adder64_operand_loader_if;
    import adder64_pkg::*;

    logic              Ci;
    logic [BEAT_W-1:0] D;
    logic              DValid;
    logic              DReady;
    logic [OP_W-1:0]   S;
    logic              Co;
    logic              OValid;
    logic              OReady;
`ifdef ADDER64_OVERFLOW_EN
    logic              Ov;

    modport master (
        output Ci, D, DValid, OReady,
        input  DReady, S, Co, OValid, Ov
    );

    modport slave (
        input  Ci, D, DValid, OReady,
        output DReady, S, Co, OValid, Ov
    );
`else
    modport master (
        output Ci, D, DValid, OReady,
        input  DReady, S, Co, OValid
    );

    modport slave (
        input  Ci, D, DValid, OReady,
        output DReady, S, Co, OValid
    );
`endif

endinterface

// File: rtl/adder64_operand_loader_fa.sv
// 64-bit ripple-carry full adder used by the operand loader.
module FullAdder64Bit (
    input  logic        Ci,
    input  logic [63:0] A,
    input  logic [63:0] B,
    output logic [63:0] S,
    output logic        Co
);

    logic w_c;

    always_comb begin
        S   = '0;
        w_c = Ci;
        for (int i = 0; i < 64; i++) begin
            S[i] = A[i] ^ B[i] ^ w_c;
            w_c  = (A[i] & B[i]) | (w_c & (A[i] ^ B[i]));
        end
        Co = w_c;
    end

endmodule

// File: rtl/adder64_operand_loader.sv
// Collects A, B and Ci over a 16-bit beat bus, adds them, holds the result.
// Define ADDER64_OVERFLOW_EN to add the registered signed-overflow output Ov.
module adder64_operand_loader
    import adder64_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    adder64_operand_loader_if.slave bus
);

    state_t          r_state;
    state_t          w_next;
    cnt_t            r_cnt;
    logic [OP_W-1:0] r_a;
    logic [OP_W-1:0] r_b;
    logic            r_ci;
    logic            r_rdy;
    logic            r_ovld;
    logic [OP_W-1:0] r_s;
    logic            r_co;
    logic [OP_W-1:0] w_s;
    logic            w_co;
    logic            w_acc;
    logic            w_ohs;
    logic [5:0]      w_lsb;

    assign w_acc = r_rdy & bus.DValid & (r_state == LOAD);
    assign w_ohs = r_ovld & bus.OReady & (r_state == DONE);
    assign w_lsb = {r_cnt[1:0], 4'b0000};

    FullAdder64Bit u_fa (
        .Ci (r_ci),
        .A  (r_a),
        .B  (r_b),
        .S  (w_s),
        .Co (w_co)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            LOAD: if (w_acc && r_cnt == cnt_t'(TOTAL_BEATS - 1)) w_next = CALC;
            CALC: w_next = DONE;
            DONE: if (w_ohs) w_next = LOAD;
            default: w_next = LOAD;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= LOAD;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rdy   <= (w_next == LOAD);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_ci   <= 1'b0;
            r_ovld <= 1'b0;
            r_s    <= '0;
            r_co   <= 1'b0;
        end else begin
            if (w_acc) begin
                r_cnt <= r_cnt + 3'd1;
                if (!r_cnt[2]) r_a[w_lsb +: BEAT_W] <= bus.D;
                else           r_b[w_lsb +: BEAT_W] <= bus.D;
                if (r_cnt == '0) r_ci <= bus.Ci;
            end
            if (r_state == CALC) begin
                r_s    <= w_s;
                r_co   <= w_co;
                r_ovld <= 1'b1;
            end
            if (w_ohs) begin
                r_ovld <= 1'b0;
                r_cnt  <= '0;
            end
        end
    end

    assign bus.DReady = r_rdy;
    assign bus.OValid = r_ovld;
    assign bus.S      = r_s;
    assign bus.Co     = r_co;

`ifdef ADDER64_OVERFLOW_EN
    logic r_ov;
    logic w_ov;

    assign w_ov = (r_a[OP_W-1] == r_b[OP_W-1]) & (w_s[OP_W-1] != r_a[OP_W-1]);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                    r_ov <= 1'b0;
        else if (r_state == CALC) r_ov <= w_ov;
    end

    assign bus.Ov = r_ov;
`endif

endmodule
